clock_tick_gen: RTL and testbench

- Parametrised, multi-channel clock-enable generator driven from the on-chip oscillator clock (53.20 MHz nominal).
- Produces NUM_CH independent one-cycle tick enables at runtime-programmable divide ratios. Consumers include the I2C bit-rate, PWM and sampling timers.
- Adds an oscillator-settling lock interval, a glitch-free divisor reload and a global phase-align. All downstream logic stays on the single clk domain; no derived clocks are created.

---
 rtl/clock_tick_gen.sv | 149 ++++++++++++++
 tb/tb_clock_tick_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_tick_gen.sv
// Multi-channel clock-enable generator: lock interval, glitch-free divisor reload, global phase align.
// Optional square-wave enables are built only when CLOCK_TICK_SQUARE_EN is defined.
module clock_tick_gen #(
    parameter int CLK_FREQ_HZ = 53200000,
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DIV_RST     = 532,
    parameter int LOCK_CYCLES = 1024,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    input  logic              sync_all,
    output logic              locked,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq_out
);

    localparam int LK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [LK_W-1:0] LOCK_END = LK_W'(LOCK_CYCLES);

    if (NUM_CH < 1 || NUM_CH > 16 || LOCK_CYCLES < 1 || CLK_FREQ_HZ < 1) begin : g_bad_param
        $error("clock_tick_gen: parameter out of range");
    end

    logic [LK_W-1:0]  r_lock_cnt;
    logic             r_locked;
    logic             r_err;
    logic [DIV_W-1:0] r_cnt    [NUM_CH];
    logic [DIV_W-1:0] r_div    [NUM_CH];
    logic [DIV_W-1:0] r_shadow [NUM_CH];
    logic [NUM_CH-1:0] r_tick;

    logic              w_accept;
    logic              w_ch_ok;
    logic [NUM_CH-1:0] w_wr_hit;
    logic [NUM_CH-1:0] w_wrap;

    assign w_accept = cfg_valid & r_locked;
    assign w_ch_ok  = (int'(cfg_ch) < NUM_CH);

    // Per-channel decode of write targeting and end-of-period detection
    always_comb begin
        w_wr_hit = '0;
        w_wrap   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr_hit[i] = w_accept && w_ch_ok && (int'(cfg_ch) == i);
            if (r_div[i] != '0) begin
                w_wrap[i] = (r_cnt[i] == (r_div[i] - DIV_W'(1)));
            end else begin
                w_wrap[i] = 1'b0;
            end
        end
    end

    // Oscillator settling counter; locked latches until the next reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (!r_locked) begin
            r_lock_cnt <= r_lock_cnt + LK_W'(1);
            r_locked   <= (r_lock_cnt == LOCK_END);
        end
    end

    // Out-of-range channel write flag, one cycle after the accepted write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_ch_ok;
        end
    end

    // Channel counters, active/shadow divisors and tick enables
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]    <= '0;
                r_div[i]    <= DIV_W'(DIV_RST);
                r_shadow[i] <= DIV_W'(DIV_RST);
            end
        end else if (!r_locked) begin
            r_tick <= '0;
        end else if (sync_all) begin
            // A write on the sync edge bypasses the shadow and is active at once
            r_tick <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
                if (w_wr_hit[i]) begin
                    r_div[i]    <= cfg_div;
                    r_shadow[i] <= cfg_div;
                end else begin
                    r_div[i] <= r_shadow[i];
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr_hit[i]) begin
                    r_shadow[i] <= cfg_div;
                end
                if (r_div[i] == '0) begin
                    r_cnt[i]  <= '0;
                    r_div[i]  <= r_shadow[i];
                    r_tick[i] <= 1'b0;
                end else if (w_wrap[i]) begin
                    r_cnt[i]  <= '0;
                    r_div[i]  <= r_shadow[i];
                    r_tick[i] <= 1'b1;
                end else begin
                    r_cnt[i]  <= r_cnt[i] + DIV_W'(1);
                    r_tick[i] <= 1'b0;
                end
            end
        end
    end

`ifdef CLOCK_TICK_SQUARE_EN
    logic [NUM_CH-1:0] r_sq;

    // Square-wave enables flip on every produced tick; disabled channels hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq <= '0;
        end else if (r_locked && sync_all) begin
            r_sq <= '0;
        end else if (r_locked) begin
            r_sq <= r_sq ^ w_wrap;
        end
    end

    assign sq_out = r_sq;
`else
    assign sq_out = '0;
`endif

    assign locked    = r_locked;
    assign cfg_ready = r_locked;
    assign cfg_err   = r_err;
    assign tick      = r_tick;

endmodule

// File: tb/tb_clock_tick_gen.sv
// Directed bench for clock_tick_gen: tick-time model built from divisor segments plus a
// scoreboard queue; a second small instance exercises the out-of-range channel error.
module tb_clock_tick_gen;

    localparam int L1 = 1024;
    localparam int D1 = 532;
    localparam int L2 = 4;
    localparam int D2 = 6;

    logic        clk = 1'b0;
    logic        rst, cfg_valid, sync_all;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_ready, cfg_err, locked;
    logic [3:0]  tick, sq_out;

    logic        rst2, v2, sync2;
    logic [1:0]  ch2;
    logic [7:0]  div2;
    logic        ready2, err2, locked2;
    logic [2:0]  tick2, sq2;

    clock_tick_gen #(.NUM_CH(4), .DIV_W(16), .DIV_RST(D1), .LOCK_CYCLES(L1)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err), .sync_all(sync_all),
        .locked(locked), .tick(tick), .sq_out(sq_out)
    );

    clock_tick_gen #(.NUM_CH(3), .DIV_W(8), .DIV_RST(D2), .LOCK_CYCLES(L2)) dut2 (
        .clk(clk), .rst(rst2), .cfg_valid(v2), .cfg_ready(ready2),
        .cfg_ch(ch2), .cfg_div(div2), .cfg_err(err2), .sync_all(sync2),
        .locked(locked2), .tick(tick2), .sq_out(sq2)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int start; int base; int per; } seg_t;
    typedef struct packed {
        logic [3:0] tick; logic [3:0] sq; logic lk; logic err;
        logic lk2; logic err2; logic [2:0] tick2;
    } exp_t;

    seg_t segs[$];
    exp_t sb[$];
    int   shadow_exp[4];
    logic [3:0] sq_exp;
    int   cyc, lock_at, lock2_at, err2_cyc;
    int   checks, errors;
    bit   sync_now;

    // Tick expected at cycle c: the latest divisor segment starting at or before c decides
    function automatic bit model_tick(int ch, int c);
        int  b = 0;
        int  p = 0;
        bit  found = 1'b0;
        foreach (segs[k]) begin
            if (segs[k].ch == ch && segs[k].start <= c) begin
                b = segs[k].base; p = segs[k].per; found = 1'b1;
            end
        end
        return found && (p > 0) && (c > b) && (((c - b) % p) == 0);
    endfunction

    task automatic drop_after(int ch, int c);
        for (int k = segs.size() - 1; k >= 0; k--) begin
            if (segs[k].ch == ch && segs[k].start > c) segs.delete(k);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", name, cyc, obs, expv);
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        exp_t o;
        int   c = cyc + 1;
        e = '0;
        e.lk = (lock_at >= 0) && (c >= lock_at);
        for (int ch = 0; ch < 4; ch++) e.tick[ch] = e.lk && model_tick(ch, c);
        if (sync_now) begin
            sq_exp = '0;
        end else begin
`ifdef CLOCK_TICK_SQUARE_EN
            sq_exp = sq_exp ^ e.tick;
`endif
        end
        e.sq    = sq_exp;
        e.err   = 1'b0;
        e.lk2   = (lock2_at >= 0) && (c >= lock2_at);
        e.err2  = (c == err2_cyc);
        e.tick2 = (e.lk2 && c > lock2_at && ((c - lock2_at) % D2) == 0) ? 3'b111 : 3'b000;
        sb.push_back(e);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        o = sb.pop_front();
        chk({tag, ":tick"},    16'(tick),      16'(o.tick));
        chk({tag, ":sq_out"},  16'(sq_out),    16'(o.sq));
        chk({tag, ":locked"},  16'(locked),    16'(o.lk));
        chk({tag, ":ready"},   16'(cfg_ready), 16'(o.lk));
        chk({tag, ":cfg_err"}, 16'(cfg_err),   16'(o.err));
        chk({tag, ":locked2"}, 16'(locked2),   16'(o.lk2));
        chk({tag, ":ready2"},  16'(ready2),    16'(o.lk2));
        chk({tag, ":err2"},    16'(err2),      16'(o.err2));
        chk({tag, ":tick2"},   16'(tick2),     16'(o.tick2));
    endtask

    task automatic reset1(int n);
        rst = 1'b1; lock_at = -1; segs.delete(); sq_exp = '0;
        for (int ch = 0; ch < 4; ch++) shadow_exp[ch] = D1;
        repeat (n) step("reset");
        rst = 1'b0;
        lock_at = cyc + 1 + L1;
        for (int ch = 0; ch < 4; ch++) segs.push_back('{ch, lock_at, lock_at, D1});
    endtask

    task automatic write1(int ch, int div, input string tag);
        int w = cyc + 1;
        int b = 0;
        int p = 0;
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = 16'(div);
        if (lock_at >= 0 && (w - 1) >= lock_at) begin
            foreach (segs[k]) begin
                if (segs[k].ch == ch && segs[k].start <= w) begin
                    b = segs[k].base; p = segs[k].per;
                end
            end
            drop_after(ch, w);
            if (p == 0) begin
                segs.push_back('{ch, w + 1, w + 1, div});
            end else begin
                int t = b + p * ((w - b) / p + 1);
                segs.push_back('{ch, t + 1, t, div});
            end
            shadow_exp[ch] = div;
        end
        step(tag);
        cfg_valid = 1'b0;
    endtask

    task automatic sync1(int wch, int wdiv);
        int s = cyc + 1;
        sync_all = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 2'(wch); cfg_div = 16'(wdiv);
        shadow_exp[wch] = wdiv;
        for (int ch = 0; ch < 4; ch++) begin
            drop_after(ch, s - 1);
            segs.push_back('{ch, s, s, shadow_exp[ch]});
        end
        sync_now = 1'b1;
        step("sync");
        sync_now = 1'b0; sync_all = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic write2(int ch, int div, input string tag);
        int w = cyc + 1;
        v2 = 1'b1; ch2 = 2'(ch); div2 = 8'(div);
        if (lock2_at >= 0 && (w - 1) >= lock2_at && ch >= 3) err2_cyc = w;
        step(tag);
        v2 = 1'b0;
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0; sync_now = 1'b0;
        lock2_at = -1; err2_cyc = -1;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; sync_all = 1'b0;
        rst2 = 1'b1; v2 = 1'b0; ch2 = '0; div2 = '0; sync2 = 1'b0;

        reset1(3);
        rst2 = 1'b0;
        lock2_at = cyc + 1 + L2;

        write2(3, 9, "err_unlocked");
        write1(1, 3, "wr_unlocked");
        repeat (6) step("lock_wait");
        write2(3, 9, "err_locked");
        repeat (20) step("err_after");

        while (cyc < lock_at + 650) step("default_div");

        write1(1, 10, "wr_ch1");
        write1(2, 1, "wr_ch2");
        write1(3, 0, "wr_ch3_off");
        while (cyc < lock_at + 1104) step("reload");

        write1(3, 5, "wr_ch3_on");
        repeat (30) step("ch3_run");

        write1(0, 7, "wr_ch0");
        repeat (2) step("pre_sync");
        sync1(1, 11);
        repeat (50) step("post_sync");

        reset1(2);
        while (cyc < lock_at + 540) step("relock");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
